// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-write target.
package i2c_pkg;

  localparam int unsigned I2C_SYNC_STAGES = 2;
  localparam int unsigned I2C_BYTE_BITS   = 8;
  localparam int unsigned I2C_CNT_W       = 4;
  localparam int unsigned I2C_ADDR_W      = 7;

  localparam logic [I2C_ADDR_W-1:0] I2C_DEFAULT_ADDR = 7'h1A;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_SUB,
    S_SUB_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
`ifdef I2C_SLAVE_READ_EN
    ,
    S_RD,
    S_RD_ACK
`endif
  } i2c_slv_state_t;

  // True when the address byte selects this device with the given R/W bit.
  function automatic logic addr_hit(input logic [I2C_BYTE_BITS-1:0] addr_byte,
                                    input logic [I2C_ADDR_W-1:0]    dev_addr,
                                    input logic                     rw);
    return (addr_byte[I2C_BYTE_BITS-1:1] == dev_addr) && (addr_byte[0] == rw);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the CLOCK domain and flags bus edges and conditions.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic CLOCK,
  input  logic RESET,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [I2C_SYNC_STAGES-1:0] scl_sync_q;
  logic [I2C_SYNC_STAGES-1:0] sda_sync_q;
  logic                       scl_hist_q;
  logic                       sda_hist_q;
  logic                       scl_s;

  // Synchronizer chains plus one history stage; reset to the idle-bus level.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[I2C_SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[I2C_SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_sync_q[I2C_SYNC_STAGES-1];
      sda_hist_q <= sda_sync_q[I2C_SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[I2C_SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[I2C_SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_hist_q;
  assign scl_fall  = ~scl_s & scl_hist_q;
  // SDA may only change with SCL high (both samples) for START/STOP.
  assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target turning [addr+W, sub-addr, data...] writes into register strobes.
// Optional read path: define I2C_SLAVE_READ_EN.
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = I2C_DEFAULT_ADDR
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     I2C_SCLK,
  inout  wire                      I2C_SDAT,
  output logic [I2C_BYTE_BITS-1:0] WR_ADDR,
  output logic [I2C_BYTE_BITS-1:0] WR_DATA,
  output logic                     WR_STB,
  output logic [I2C_BYTE_BITS-1:0] RD_ADDR,
  input  logic [I2C_BYTE_BITS-1:0] RD_DATA,
  output logic                     BUSY
);

  localparam logic [I2C_CNT_W-1:0] CNT_FULL = I2C_CNT_W'(I2C_BYTE_BITS);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_slv_state_t           state_q, state_d;
  logic [I2C_CNT_W-1:0]     cnt_q, cnt_d;
  logic [I2C_BYTE_BITS-1:0] shift_q, shift_d;
  logic [I2C_BYTE_BITS-1:0] sub_q, sub_d;
  logic [I2C_BYTE_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [I2C_BYTE_BITS-1:0] wr_data_q, wr_data_d;
  logic                     sda_oe_q, sda_oe_d;
  logic                     wr_stb_q, wr_stb_d;
  logic                     busy_q, busy_d;
`ifdef I2C_SLAVE_READ_EN
  logic                     rw_q, rw_d;
`else
  logic [I2C_BYTE_BITS-1:0] rd_data_unused;
  assign rd_data_unused = RD_DATA;
`endif

  logic                     bit_rise;
  logic                     byte_done;
  logic [I2C_BYTE_BITS-1:0] shift_in;
  logic [I2C_CNT_W-1:0]     cnt_inc;

  i2c_line_sync u_sync (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .scl_i     (I2C_SCLK),
    .sda_i     (I2C_SDAT),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign bit_rise  = scl_rise && (cnt_q < CNT_FULL);
  assign byte_done = scl_fall && (cnt_q == CNT_FULL);
  assign shift_in  = {shift_q[I2C_BYTE_BITS-2:0], sda_s};
  assign cnt_inc   = cnt_q + I2C_CNT_W'(1);

  // Next-state and output decode; START/STOP override any SCL edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    sub_d     = sub_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sda_oe_d  = sda_oe_q;
    wr_stb_d  = 1'b0;
    busy_d    = busy_q;
`ifdef I2C_SLAVE_READ_EN
    rw_d      = rw_q;
`endif
    if (stop_det) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = S_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_IGNORE: begin
        end
        S_ADDR: begin
          if (bit_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
          end else if (byte_done) begin
            cnt_d = '0;
            if (addr_hit(shift_q, SLAVE_ADDR, 1'b0)) begin
              state_d  = S_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
`ifdef I2C_SLAVE_READ_EN
              rw_d     = 1'b0;
            end else if (addr_hit(shift_q, SLAVE_ADDR, 1'b1)) begin
              state_d  = S_ADDR_ACK;
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = 1'b1;
`endif
            end else begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            state_d  = S_SUB;
`ifdef I2C_SLAVE_READ_EN
            // MSB goes out on the same fall that ends the ACK.
            if (rw_q) begin
              state_d  = S_RD;
              shift_d  = RD_DATA;
              sda_oe_d = ~RD_DATA[I2C_BYTE_BITS-1];
              cnt_d    = I2C_CNT_W'(1);
            end
`endif
          end
        end
        S_SUB: begin
          if (bit_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
          end else if (byte_done) begin
            cnt_d    = '0;
            sub_d    = shift_q;
            sda_oe_d = 1'b1;
            state_d  = S_SUB_ACK;
          end
        end
        S_SUB_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_DATA;
          end
        end
        S_DATA: begin
          if (bit_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
          end else if (byte_done) begin
            cnt_d     = '0;
            sda_oe_d  = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = sub_q;
            wr_data_d = shift_q;
            state_d   = S_DATA_ACK;
          end
        end
        S_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            sub_d    = sub_q + I2C_BYTE_BITS'(1);
            state_d  = S_DATA;
          end
        end
`ifdef I2C_SLAVE_READ_EN
        S_RD: begin
          if (scl_fall) begin
            if (cnt_q == CNT_FULL) begin
              cnt_d    = '0;
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              sda_oe_d = ~shift_q[I2C_BYTE_BITS-2];
              shift_d  = {shift_q[I2C_BYTE_BITS-2:0], 1'b0};
              cnt_d    = cnt_inc;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = S_IGNORE;
            end else begin
              sub_d = sub_q + I2C_BYTE_BITS'(1);
            end
          end else if (scl_fall) begin
            state_d  = S_RD;
            shift_d  = RD_DATA;
            sda_oe_d = ~RD_DATA[I2C_BYTE_BITS-1];
            cnt_d    = I2C_CNT_W'(1);
          end
        end
`endif
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset releases SDA immediately.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      sub_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sda_oe_q  <= 1'b0;
      wr_stb_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
      rw_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      sub_q     <= sub_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sda_oe_q  <= sda_oe_d;
      wr_stb_q  <= wr_stb_d;
      busy_q    <= busy_d;
`ifdef I2C_SLAVE_READ_EN
      rw_q      <= rw_d;
`endif
    end
  end

  assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;
  assign WR_STB   = wr_stb_q;
  assign BUSY     = busy_q;
`ifdef I2C_SLAVE_READ_EN
  assign RD_ADDR  = sub_q;
`else
  assign RD_ADDR  = '0;
`endif

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave acting as a simple I2C bus master.
module tb_i2c_reg_slave;

  localparam int Q = 50;  // quarter SCL period; CLOCK period is 10

  logic       CLOCK;
  logic       RESET;
  logic       scl;
  logic       m_low;
  wire        sda_w;
  logic [7:0] WR_ADDR, WR_DATA, RD_ADDR, rd_data;
  logic       WR_STB, BUSY;

  int tests = 0;
  int fails = 0;
  logic [15:0] stb_log[$];

  assign sda_w = m_low ? 1'b0 : 1'bz;
  pullup (sda_w);

  // Bench register bank seen by the read path.
  assign rd_data = (RD_ADDR == 8'h20) ? 8'hA5 : 8'h3C;

  i2c_reg_slave dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda_w),
    .WR_ADDR  (WR_ADDR),
    .WR_DATA  (WR_DATA),
    .WR_STB   (WR_STB),
    .RD_ADDR  (RD_ADDR),
    .RD_DATA  (rd_data),
    .BUSY     (BUSY)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Record every strobe cycle, sampled away from the active edge.
  always @(negedge CLOCK) begin
    if (RESET === 1'b1 && WR_STB === 1'b1) stb_log.push_back({WR_ADDR, WR_DATA});
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] stb_at(input int idx);
    return (stb_log.size() > idx) ? stb_log[idx] : 16'hDEAD;
  endfunction

  task automatic bus_start();
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q m_low = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q m_low = 1'b1;
    #Q scl = 1'b1;
    #Q m_low = 1'b0;
    #(4*Q);
  endtask

  task automatic bit_out(input logic b);
    #Q m_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q b = sda_w;
    #Q scl = 1'b0;
  endtask

  task automatic byte_out(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(v[i]);
    bit_in(ack);
  endtask

  task automatic byte_in(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      v[i] = b;
    end
  endtask

  initial begin
    logic       ack;
    logic [7:0] rbyte;
    RESET = 1'b0;
    scl   = 1'b1;
    m_low = 1'b0;
    repeat (5) @(posedge CLOCK);
    #1;
    check("rst_sda", {15'd0, sda_w}, 16'h1);
    check("rst_stb", {15'd0, WR_STB}, 16'h0);
    check("rst_wr_addr", {8'd0, WR_ADDR}, 16'h00);
    check("rst_wr_data", {8'd0, WR_DATA}, 16'h00);
    check("rst_rd_addr", {8'd0, RD_ADDR}, 16'h00);
    check("rst_busy", {15'd0, BUSY}, 16'h0);
    @(negedge CLOCK) RESET = 1'b1;
    repeat (5) @(posedge CLOCK);

    // Single write 0x34, 0x0C, 0x5A
    bus_start();
    byte_out(8'h34, ack); check("w1_addr_ack", {15'd0, ack}, 16'h0);
    check("w1_busy", {15'd0, BUSY}, 16'h1);
    byte_out(8'h0C, ack); check("w1_sub_ack", {15'd0, ack}, 16'h0);
    byte_out(8'h5A, ack); check("w1_data_ack", {15'd0, ack}, 16'h0);
    bus_stop();
    check("w1_busy_stop", {15'd0, BUSY}, 16'h0);
    check("w1_stb_count", 16'(stb_log.size()), 16'd1);
    check("w1_stb0", stb_at(0), 16'h0C5A);
    check("w1_hold", {WR_ADDR, WR_DATA}, 16'h0C5A);

    // Wrong address 0x36: no ACKs, no strobe
    bus_start();
    byte_out(8'h36, ack); check("bad_addr_nack", {15'd0, ack}, 16'h1);
    check("bad_busy", {15'd0, BUSY}, 16'h0);
    byte_out(8'h0C, ack); check("bad_sub_nack", {15'd0, ack}, 16'h1);
    byte_out(8'h5A, ack); check("bad_data_nack", {15'd0, ack}, 16'h1);
    bus_stop();
    check("bad_stb_count", 16'(stb_log.size()), 16'd1);
    check("bad_hold", {WR_ADDR, WR_DATA}, 16'h0C5A);

    // Burst with sub-address wrap
    bus_start();
    byte_out(8'h34, ack);
    byte_out(8'hFF, ack);
    byte_out(8'h11, ack); check("wrap_ack1", {15'd0, ack}, 16'h0);
    byte_out(8'h22, ack); check("wrap_ack2", {15'd0, ack}, 16'h0);
    bus_stop();
    check("wrap_stb_count", 16'(stb_log.size()), 16'd3);
    check("wrap_stb1", stb_at(1), 16'hFF11);
    check("wrap_stb2", stb_at(2), 16'h0022);

    // Partial sub-address, then repeated START
    bus_start();
    byte_out(8'h34, ack);
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    bus_start();
    byte_out(8'h34, ack); check("rs_addr_ack", {15'd0, ack}, 16'h0);
    byte_out(8'h10, ack);
    byte_out(8'h77, ack);
    bus_stop();
    check("rs_stb_count", 16'(stb_log.size()), 16'd4);
    check("rs_stb3", stb_at(3), 16'h1077);

    // Reset during data bit 5 (bit value 1, bus released)
    bus_start();
    byte_out(8'h34, ack);
    byte_out(8'h40, ack);
    bit_out(1'b1); bit_out(1'b0);
    #Q m_low = 1'b0;
    #Q scl = 1'b1;
    #Q check("mid_busy_pre", {15'd0, BUSY}, 16'h1);
    RESET = 1'b0;
    #1;
    check("mid_rst_sda", {15'd0, sda_w}, 16'h1);
    check("mid_rst_busy", {15'd0, BUSY}, 16'h0);
    #(Q-1) scl = 1'b0;
    #20 RESET = 1'b1;
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    bit_in(ack); check("mid_no_ack", {15'd0, ack}, 16'h1);
    bus_stop();
    check("mid_stb_count", 16'(stb_log.size()), 16'd4);
    bus_start();
    byte_out(8'h34, ack); check("post_addr_ack", {15'd0, ack}, 16'h0);
    byte_out(8'h07, ack);
    byte_out(8'hC3, ack);
    bus_stop();
    check("post_stb_count", 16'(stb_log.size()), 16'd5);
    check("post_stb4", stb_at(4), 16'h07C3);

`ifdef I2C_SLAVE_READ_EN
    // Read 0x20 after setting the sub-address, master NACKs
    bus_start();
    byte_out(8'h34, ack);
    byte_out(8'h20, ack);
    bus_start();
    byte_out(8'h35, ack); check("rd_addr_ack", {15'd0, ack}, 16'h0);
    check("rd_addr", {8'd0, RD_ADDR}, 16'h20);
    byte_in(rbyte); check("rd_byte", {8'd0, rbyte}, 16'hA5);
    bit_out(1'b1);
    check("rd_addr_nack", {8'd0, RD_ADDR}, 16'h20);
    bit_in(ack); check("rd_ignore", {15'd0, ack}, 16'h1);
    bus_stop();
    check("rd_busy_stop", {15'd0, BUSY}, 16'h0);
    check("rd_stb_count", 16'(stb_log.size()), 16'd5);
`else
    // Read request is treated as an address mismatch
    rbyte = 8'h00;
    bus_start();
    byte_out(8'h35, ack); check("rd_nack", {15'd0, ack}, 16'h1);
    check("rd_busy", {15'd0, BUSY}, 16'h0);
    byte_in(rbyte); check("rd_released", {8'd0, rbyte}, 16'hFF);
    bus_stop();
    check("rd_addr_tied", {8'd0, RD_ADDR}, 16'h00);
    check("rd_stb_count", 16'(stb_log.size()), 16'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_reg_slave.md
# i2c_reg_slave

I2C target (slave) that receives `[SLAVE_ADDR+R/W, SUB_ADDR, DATA...]` write transactions and turns each data byte into a single-cycle register write strobe. It is the responder for the team's 24-bit I2C write master. It sits on any on-chip register bank that must be configurable over the same two-wire bus. It oversamples SCL/SDA with the system clock, detects START/STOP, ACKs matching bytes, and auto-increments the sub-address on bursts.

## Interface
- `SLAVE_ADDR`, 7'h1A — 7-bit device address; the write address byte on the wire is 0x34.
- `CLOCK` in 1 — system clock; must be ≥ 8× SCL frequency.
- `RESET` in 1 — reset RESET, asynchronous, active-low; clock CLOCK.
- `I2C_SCLK` in 1 — bus clock from the master (input only, no clock stretching).
- `I2C_SDAT` inout 1 — open-drain data; only ever driven 0 or z.
- `WR_ADDR` out 8 — register sub-address of current write.
- `WR_DATA` out 8 — received data byte.
- `WR_STB` out 1 — one-CLOCK pulse; `WR_ADDR`/`WR_DATA` are valid in that cycle.
- `RD_ADDR` out 8 — sub-address for the read path.
- `RD_DATA` in 8 — register contents at `RD_ADDR`; sampled combinationally by the block.
- `BUSY` out 1 — high from an address-matched ACK until STOP or mismatch.

## Operation
- **Synchronization:** SCL and SDA pass through a 2-FF synchronizer plus one history FF.
  - SCL rise/fall is detected from the sync/history pair.
  - START = SDA 1→0 while SCL high.
  - STOP = SDA 0→1 while SCL high.
- **Sampling:** data bits are sampled on detected SCL rise, MSB first, into an 8-bit shifter. A 4-bit bit counter counts 0..8.
- **States:** IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, DATA, DATA_ACK, IGNORE; plus RD, RD_ACK when the read path is compiled in.
  - IDLE: wait for START → ADDR.
  - ADDR: after 8 bits, compare `byte[7:1]` with `SLAVE_ADDR` and `byte[0]`=0.
    - Match → ADDR_ACK.
    - Otherwise → IGNORE; SDA stays released.
  - ADDR_ACK / SUB_ACK / DATA_ACK (ACK phase):
    - On the SCL fall that ends bit 8, drive SDA=0.
    - On the next SCL fall, release SDA and advance.
  - SUB: after 8 bits, latch the sub-address register → SUB_ACK.
  - DATA: after 8 bits → DATA_ACK.
    - In the ACK-drive cycle, present `WR_ADDR`=sub-address and `WR_DATA`=byte, pulse `WR_STB`.
    - On leaving DATA_ACK, increment the sub-address (8-bit, 0xFF wraps to 0x00) → DATA.
  - IGNORE: wait for STOP or START.
- **START/STOP anywhere:**
  - START in any state (repeated start) → ADDR, bit counter cleared, SDA released.
  - STOP in any state → IDLE, SDA released, `BUSY`=0.
  - A partial byte at STOP is discarded with no strobe.
- **Write gating:** at most one `WR_STB` per received byte. `WR_STB` never fires for an unacknowledged address.

## Timing
- **Reset values:**
  - `I2C_SDAT`=z; `WR_STB`=0; `WR_ADDR`=0x00; `WR_DATA`=0x00; `RD_ADDR`=0x00; `BUSY`=0.
  - State = IDLE. The sub-address register is 0.
- **Edge latency:** a bus edge is acted on 3 CLOCK cycles after it occurs (2 sync + 1 detect).
  - SDA changes driven by this block occur 3–4 CLOCK cycles after the SCL fall, which provides hold time.
- **Strobe timing:** `WR_STB` is high for exactly 1 CLOCK, in the cycle the DATA_ACK SDA drive begins. `WR_ADDR`/`WR_DATA` hold until the next strobe.
- **Asynchronous reset mid-transfer:** SDA is released in the same cycle; the block returns to IDLE and ignores the rest of the transfer until a new START.
- **Edge priority:** if START/STOP and an SCL edge are detected in the same cycle, START/STOP wins.

## Configuration
- `I2C_SLAVE_READ_EN` defined: an address byte with R/W=1 and a matching address is ACKed and enters RD.
  - `RD_DATA` is loaded at the SCL fall ending the ACK, then shifted out MSB first on SCL falls. Shifting drives 0 or z only.
  - After 8 bits, SDA is released and the master ACK is sampled on SCL rise (RD_ACK).
    - ACK=0 → increment sub-address, load the next byte.
    - NACK=1 → IGNORE.
  - `RD_ADDR` tracks the sub-address.
- `I2C_SLAVE_READ_EN` not defined: R/W=1 is treated as an address mismatch (NACK, IGNORE). `RD_ADDR` is tied to 0 and `RD_DATA` is unused.

## Structure
- **Package `i2c_pkg`:**
  - State enum type `i2c_slv_state_t`.
  - Constants `I2C_SYNC_STAGES`=2 and `I2C_BYTE_BITS`=8.
  - Default slave address constant 7'h1A.
- **Sub-module `i2c_line_sync`:** 2-FF synchronizers for SCL/SDA plus history. Outputs `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `sda_s`.

## Test plan
- Write 0x34, 0x0C, 0x5A, STOP → three ACKs (SDA low on the 9th clocks); one `WR_STB` with `WR_ADDR`=0x0C, `WR_DATA`=0x5A; `BUSY` 0 after STOP.
- Address byte 0x36 then 0x0C, 0x5A → SDA never driven low, no `WR_STB`, `BUSY` stays 0.
- Burst 0x34, 0xFF, 0x11, 0x22 → strobes (0xFF, 0x11), then (0x00, 0x22), showing wrap.
- START, 0x34, 4 bits of sub-address, repeated START, 0x34, 0x10, 0x77 → exactly one strobe, with (0x10, 0x77).
- `RESET` asserted during DATA bit 5 while the block holds no ACK → SDA=z immediately, no strobe; the next full transaction writes normally.
- With `I2C_SLAVE_READ_EN`: write 0x34, 0x20, repeated START, read 0x35, `RD_DATA`=0xA5, master NACK → `RD_ADDR`=0x20, bits 1010_0101 on SDA, then IGNORE until STOP.
